// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter: round-robin arbiter that shares one spi_master_tx between
// N_REQ requesters. Captures the winner's byte, holds send until the
// transmitter reports busy, follows busy to completion and returns
// per-requester ack/done/err pulses. All outputs are registered.
module spi_tx_arbiter #(
  parameter  int N_REQ       = 4,
  parameter  int DATA_W      = 8,
  parameter  int ACK_TIMEOUT = 64,
  parameter  int GAP_CYCLES  = 4,
  localparam int ID_W        = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          ack,
  output logic [N_REQ-1:0]          done,
  output logic [N_REQ-1:0]          err,
  output logic [DATA_W-1:0]         spi_data,
  output logic                      spi_send,
  input  logic                      spi_busy,
  output logic                      active,
  output logic [ID_W-1:0]           owner
);

  typedef enum logic [1:0] {IDLE, LAUNCH, XFER, GAP} state_t;

  localparam int CNT_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int SW      = ID_W + 1;
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
  // GAP_CYCLES of 0 and 1 both spend exactly one cycle in GAP
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [ID_W-1:0]   rr_ptr, rr_n;
  logic [ID_W-1:0]   owner_n, owner_next_ptr;
  logic [N_REQ-1:0]  ack_n, done_n, err_n;
  logic [DATA_W-1:0] data_n;
  logic              send_n;

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [SW-1:0]     scan_idx;
  logic [DATA_W-1:0] grant_byte;

  // Rotating priority scan: first set req bit at or above rr_ptr, wrapping
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      scan_idx = {1'b0, rr_ptr} + SW'(i);
      if (scan_idx >= SW'(N_REQ))
        scan_idx = scan_idx - SW'(N_REQ);
      if (!grant_found && req[scan_idx[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[ID_W-1:0];
      end
    end
  end

  // Select the winning requester's byte
  always_comb begin
    grant_byte = '0;
    for (int unsigned j = 0; j < N_REQ; j++)
      if (grant_idx == ID_W'(j))
        grant_byte = req_data[j*DATA_W +: DATA_W];
  end

  assign owner_next_ptr = (owner == ID_W'(N_REQ - 1)) ? '0 : owner + 1'b1;

  // Next-state and next-output logic for the launch/transfer sequence
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rr_n    = rr_ptr;
    owner_n = owner;
    data_n  = spi_data;
    send_n  = spi_send;
    ack_n   = '0;
    done_n  = '0;
    err_n   = '0;
    unique case (state)
      IDLE: begin
        if (grant_found && !spi_busy) begin
          state_n          = LAUNCH;
          cnt_n            = '0;
          send_n           = 1'b1;
          data_n           = grant_byte;
          owner_n          = grant_idx;
          ack_n[grant_idx] = 1'b1;
        end
      end
      LAUNCH: begin
        if (spi_busy) begin
          state_n = XFER;
          send_n  = 1'b0;
        end else if (cnt == ACK_LAST) begin
          state_n      = GAP;
          send_n       = 1'b0;
          err_n[owner] = 1'b1;
          cnt_n        = '0;
          rr_n         = owner_next_ptr;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      XFER: begin
        if (!spi_busy) begin
          state_n       = GAP;
          done_n[owner] = 1'b1;
          cnt_n         = '0;
          rr_n          = owner_next_ptr;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) state_n = IDLE;
        else                 cnt_n   = cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs; reset clears everything immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rr_ptr   <= '0;
      owner    <= '0;
      spi_data <= '0;
      spi_send <= 1'b0;
      ack      <= '0;
      done     <= '0;
      err      <= '0;
      active   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      rr_ptr   <= rr_n;
      owner    <= owner_n;
      spi_data <= data_n;
      spi_send <= send_n;
      ack      <= ack_n;
      done     <= done_n;
      err      <= err_n;
      active   <= (state_n != IDLE);
    end
  end

endmodule
